bbc_bus_sequencer: RTL and testbench

- Target-side sequencer that runs the BBC bus cycle for a CPU access originating in the fast hsclk domain.
- The CPU side raises a request. The block aligns it to the slow bbc_phi0 bus clock, then drives address, rnw and write data through one full phi1/phi2 BBC cycle.
- Read data is captured at phi2 end and returned with a one-cycle acknowledge.
- It sits between the CPU address decode and the BBC bus pins, replacing the direct phi0-locked glue once the CPU runs from hsclk.

---
 rtl/bbc_bus_sequencer_pkg.sv | 26 ++
 rtl/bbc_bus_sequencer_phi0_sync.sv | 32 +++
 rtl/bbc_bus_sequencer.sv | 144 ++++++++++++++
 tb/tb_bbc_bus_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bbc_bus_sequencer_pkg.sv
// Shared types and constants for the BBC bus sequencer.
package bbc_bus_sequencer_pkg;

    localparam int unsigned ADR_W              = 16;
    localparam int unsigned DATA_W             = 8;
    localparam int unsigned HOLD_W             = 3;
    localparam int unsigned DEF_SYNC_STAGES    = 2;
    localparam int unsigned DEF_HOLD_CYCLES    = 1;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 255;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_PHI1,
        ST_PHI2,
        ST_HOLD,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic              rnw;
        logic [ADR_W-1:0]  adr;
        logic [DATA_W-1:0] wdata;
    } bbc_req_t;

endpackage

// File: rtl/bbc_bus_sequencer_phi0_sync.sv
// Synchronises raw bbc_phi0 into hsclk and produces registered rise/fall pulses.
module bbc_phi0_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic hsclk,
    input  logic resetb,
    input  logic bbc_phi0,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_prev;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge hsclk or negedge resetb) begin
        if (!resetb) begin
            sync_q <= '0;
            s_prev <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bbc_phi0};
            s_prev <= s;
            fall   <= s_prev & ~s;
            rise   <= ~s_prev & s;
        end
    end

endmodule

// File: rtl/bbc_bus_sequencer.sv
// Runs one phi0-aligned BBC bus cycle per CPU request from the hsclk domain.
module bbc_bus_sequencer
    import bbc_bus_sequencer_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int unsigned HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              hsclk,
    input  logic              resetb,
    input  logic              bbc_phi0,
    input  logic              cpu_req,
    input  logic              cpu_rnw,
    input  logic [ADR_W-1:0]  cpu_adr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic              cpu_err,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_busy,
    output logic [ADR_W-1:0]  bbc_adr,
    output logic              bbc_rnw,
    output logic [DATA_W-1:0] bbc_wdata,
    output logic              bbc_data_oe,
    input  logic [DATA_W-1:0] bbc_rdata
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e              state, state_d;
    bbc_req_t            req_q, req_d;
    logic [HOLD_W-1:0]   hold_cnt, hold_d;
    logic [WD_W-1:0]     wd_cnt, wd_d;
    logic                oe_d, ack_d, err_d, busy_d;
    logic [DATA_W-1:0]   rdata_d;
    logic                rise, fall;
    logic                tmo_c;
    logic                wd_active_c;

    bbc_phi0_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .hsclk   (hsclk),
        .resetb  (resetb),
        .bbc_phi0(bbc_phi0),
        .rise    (rise),
        .fall    (fall)
    );

    assign bbc_adr   = req_q.adr;
    assign bbc_rnw   = req_q.rnw;
    assign bbc_wdata = req_q.wdata;

    // Next-state and next-output logic; a phi0 edge always beats the watchdog.
    always_comb begin
        state_d     = state;
        req_d       = req_q;
        hold_d      = hold_cnt;
        wd_d        = wd_cnt;
        oe_d        = bbc_data_oe;
        rdata_d     = cpu_rdata;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        wd_active_c = (state == ST_ALIGN) || (state == ST_PHI1) || (state == ST_PHI2);
        tmo_c       = wd_active_c && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) && !(rise || fall);

        if (wd_active_c) begin
            wd_d = (rise || fall) ? '0 : wd_cnt + WD_W'(1);
        end

        case (state)
            ST_IDLE: begin
                if (cpu_req) begin
                    req_d   = '{rnw: cpu_rnw, adr: cpu_adr, wdata: cpu_wdata};
                    wd_d    = '0;
                    state_d = fall ? ST_PHI1 : ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                if (fall)       state_d = ST_PHI1;
                else if (tmo_c) state_d = ST_DONE;
            end
            ST_PHI1: begin
                if (rise) begin
                    state_d = ST_PHI2;
                    oe_d    = ~req_q.rnw;
                end else if (tmo_c) begin
                    state_d = ST_DONE;
                end
            end
            ST_PHI2: begin
                if (req_q.rnw) rdata_d = bbc_rdata;
                if (fall) begin
                    if (HOLD_CYCLES == 0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_HOLD;
                        hold_d  = HOLD_W'(HOLD_CYCLES);
                    end
                end else if (tmo_c) begin
                    state_d = ST_DONE;
                    rdata_d = cpu_rdata;
                end
            end
            ST_HOLD: begin
                if (hold_cnt <= HOLD_W'(1)) state_d = ST_DONE;
                else                        hold_d  = hold_cnt - HOLD_W'(1);
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if ((state_d == ST_DONE) && (state != ST_DONE)) begin
            ack_d = 1'b1;
            err_d = tmo_c;
            oe_d  = 1'b0;
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge hsclk or negedge resetb) begin
        if (!resetb) begin
            state       <= ST_IDLE;
            req_q       <= '{rnw: 1'b1, adr: '0, wdata: '0};
            hold_cnt    <= '0;
            wd_cnt      <= '0;
            bbc_data_oe <= 1'b0;
            cpu_ack     <= 1'b0;
            cpu_err     <= 1'b0;
            cpu_rdata   <= '0;
            cpu_busy    <= 1'b0;
        end else begin
            state       <= state_d;
            req_q       <= req_d;
            hold_cnt    <= hold_d;
            wd_cnt      <= wd_d;
            bbc_data_oe <= oe_d;
            cpu_ack     <= ack_d;
            cpu_err     <= err_d;
            cpu_rdata   <= rdata_d;
            cpu_busy    <= busy_d;
        end
    end

endmodule

// File: tb/tb_bbc_bus_sequencer.sv
// Scoreboard bench for bbc_bus_sequencer: phi0 = 8 low + 8 high hsclk, hold 1, timeout 255.
module tb_bbc_bus_sequencer;

    localparam int HALF  = 8;
    localparam int HOLD  = 1;
    localparam int TMO   = 255;
    localparam int SYNC  = 2;
    localparam int BBC_CYC = 2 * HALF;

    logic        hsclk;
    logic        resetb;
    logic        bbc_phi0;
    logic        cpu_req;
    logic        cpu_rnw;
    logic [15:0] cpu_adr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic        cpu_err;
    logic [7:0]  cpu_rdata;
    logic        cpu_busy;
    logic [15:0] bbc_adr;
    logic        bbc_rnw;
    logic [7:0]  bbc_wdata;
    logic        bbc_data_oe;
    logic [7:0]  bbc_rdata;

    bbc_bus_sequencer #(
        .SYNC_STAGES   (SYNC),
        .HOLD_CYCLES   (HOLD),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .hsclk      (hsclk),
        .resetb     (resetb),
        .bbc_phi0   (bbc_phi0),
        .cpu_req    (cpu_req),
        .cpu_rnw    (cpu_rnw),
        .cpu_adr    (cpu_adr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_err    (cpu_err),
        .cpu_rdata  (cpu_rdata),
        .cpu_busy   (cpu_busy),
        .bbc_adr    (bbc_adr),
        .bbc_rnw    (bbc_rnw),
        .bbc_wdata  (bbc_wdata),
        .bbc_data_oe(bbc_data_oe),
        .bbc_rdata  (bbc_rdata)
    );

    typedef struct {
        logic        rnw;
        logic [15:0] adr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        logic        err;
        int          oe_cycles;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  salt;
    logic [7:0]  last_rdata;
    logic [7:0]  exp_wdata;
    int unsigned cyc;
    logic        phi_run;
    int          oe_cnt;
    logic        ack_prev;

    initial hsclk = 1'b0;
    always #5 hsclk = ~hsclk;

    // Free-running phi0: 8 hsclk low then 8 high, freezable to model a stuck clock.
    initial begin
        cyc      = 0;
        bbc_phi0 = 1'b0;
        forever begin
            @(posedge hsclk);
            #2;
            if (phi_run) begin
                cyc++;
                bbc_phi0 = ((cyc % BBC_CYC) >= HALF);
            end
        end
    end

    // Bus slave: a fixed byte at 0xFE40, otherwise an address hash.
    function automatic logic [7:0] bus_byte(input logic [15:0] a);
        return (a == 16'hFE40) ? 8'h5A : (a[7:0] ^ a[15:8] ^ salt);
    endfunction

    assign bbc_rdata = bus_byte(bbc_adr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per ack and checks the bus-side view of the access.
    always @(posedge hsclk) begin
        exp_t e;
        #1;
        if (!resetb) begin
            oe_cnt   = 0;
            ack_prev = 1'b0;
        end else begin
            if (bbc_data_oe) begin
                oe_cnt++;
                check("wdata_while_oe", 32'(bbc_wdata), 32'(exp_wdata));
            end
            if (cpu_ack) begin
                check("ack_one_cycle", 32'(ack_prev), 32'd0);
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_ack: got ack with no pending access at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    check("ack_err",    32'(cpu_err),   32'(e.err));
                    check("ack_rdata",  32'(cpu_rdata), 32'(e.rdata));
                    check("ack_adr",    32'(bbc_adr),   32'(e.adr));
                    check("ack_rnw",    32'(bbc_rnw),   32'(e.rnw));
                    check("oe_cycles",  32'(oe_cnt),    32'(e.oe_cycles));
                end
                oe_cnt = 0;
            end
            ack_prev = cpu_ack;
        end
    end

    // Issue one access from the current time; lat = edges from drive until ack is seen.
    task automatic do_access(input logic rnw, input logic [15:0] adr, input logic [7:0] wd,
                             input logic tmo, output int lat);
        exp_t e;
        e.rnw       = rnw;
        e.adr       = adr;
        e.wdata     = wd;
        e.err       = tmo;
        e.rdata     = (rnw && !tmo) ? bus_byte(adr) : last_rdata;
        e.oe_cycles = (!rnw && !tmo) ? HALF + HOLD : 0;
        last_rdata  = e.rdata;
        sb.push_back(e);
        exp_wdata = wd;
        cpu_req   = 1'b1;
        cpu_rnw   = rnw;
        cpu_adr   = adr;
        cpu_wdata = wd;
        lat = 0;
        while (1) begin
            @(posedge hsclk);
            lat++;
            #1;
            if (lat == 1) check("busy_on_accept", 32'(cpu_busy), 32'd1);
            if (cpu_ack) break;
            if (lat >= 600) begin
                n_cmp++;
                n_bad++;
                $display("FAIL ack_wait: no ack after %0d cycles, required one", lat);
                break;
            end
        end
        cpu_req = 1'b0;
    endtask

    task automatic wait_phase(input int ph);
        do begin
            @(posedge hsclk);
            #1;
        end while ((cyc % BBC_CYC) != ph);
    endtask

    initial begin
        int lat;
        int lo, hi;
        logic        r;
        logic [15:0] a;
        logic [7:0]  w;

        resetb     = 1'b1;
        phi_run    = 1'b1;
        cpu_req    = 1'b0;
        cpu_rnw    = 1'b1;
        cpu_adr    = '0;
        cpu_wdata  = '0;
        salt       = 8'h3C;
        last_rdata = 8'h00;
        exp_wdata  = 8'h00;
        #1 resetb  = 1'b0;
        repeat (4) @(posedge hsclk);
        #1;
        check("rst_ack",   32'(cpu_ack),     32'd0);
        check("rst_err",   32'(cpu_err),     32'd0);
        check("rst_rdata", 32'(cpu_rdata),   32'd0);
        check("rst_busy",  32'(cpu_busy),    32'd0);
        check("rst_adr",   32'(bbc_adr),     32'd0);
        check("rst_rnw",   32'(bbc_rnw),     32'd1);
        check("rst_wdata", 32'(bbc_wdata),   32'd0);
        check("rst_oe",    32'(bbc_data_oe), 32'd0);
        resetb = 1'b1;
        repeat (3) @(posedge hsclk);
        #1;

        // Directed read and write from the plan.
        do_access(1'b1, 16'hFE40, 8'h00, 1'b0, lat);
        @(posedge hsclk); #1;
        do_access(1'b0, 16'h3000, 8'hC3, 1'b0, lat);
        @(posedge hsclk); #1;

        // Request in the cycle the registered fall is visible: ALIGN is skipped.
        wait_phase(SYNC);
        do_access(1'b1, 16'h1234, 8'h00, 1'b0, lat);
        check("coincident_latency", 32'(lat), 32'(BBC_CYC + HOLD + 1));
        @(posedge hsclk); #1;

        // Back-to-back reads: busy drops for exactly the one IDLE cycle.
        do_access(1'b1, 16'h8000, 8'h00, 1'b0, lat);
        @(posedge hsclk); #1;
        check("busy_gap", 32'(cpu_busy), 32'd0);
        do_access(1'b1, 16'h8001, 8'h00, 1'b0, lat);
        @(posedge hsclk); #1;

        // Randomised accesses at random phase offsets.
        lo = BBC_CYC + HOLD + 1;
        hi = 2 * BBC_CYC + HOLD + 2;
        for (int i = 0; i < 24; i++) begin
            repeat ($urandom_range(1, 20)) @(posedge hsclk);
            #1;
            if ((i % 6) == 0) salt = 8'($urandom);
            r = 1'($urandom_range(0, 1));
            a = 16'($urandom);
            w = 8'($urandom);
            do_access(r, a, w, 1'b0, lat);
            check("latency_in_range", 32'((lat >= lo) && (lat <= hi)), 32'd1);
        end
        @(posedge hsclk); #1;

        // phi0 stuck low: both a read and a write time out with the old read data.
        wait_phase(5);
        phi_run = 1'b0;
        @(posedge hsclk); #1;
        do_access(1'b1, 16'h4444, 8'h00, 1'b0 | 1'b1, lat);
        check("timeout_rd_latency", 32'(lat), 32'(TMO + 1));
        @(posedge hsclk); #1;
        do_access(1'b0, 16'h5555, 8'hA5, 1'b1, lat);
        check("timeout_wr_latency", 32'(lat), 32'(TMO + 1));
        phi_run = 1'b1;
        @(posedge hsclk); #1;

        // Reset in the middle of a write: oe and rnw drop immediately, no ack.
        exp_wdata = 8'h77;
        cpu_req   = 1'b1;
        cpu_rnw   = 1'b0;
        cpu_adr   = 16'h2222;
        cpu_wdata = 8'h77;
        lat = 0;
        while (!bbc_data_oe && lat < 100) begin
            @(posedge hsclk); #1;
            lat++;
        end
        check("write_oe_seen", 32'(bbc_data_oe), 32'd1);
        cpu_req = 1'b0;
        repeat (2) @(posedge hsclk);
        #3 resetb = 1'b0;
        #1;
        check("rst_mid_oe",   32'(bbc_data_oe), 32'd0);
        check("rst_mid_rnw",  32'(bbc_rnw),     32'd1);
        check("rst_mid_busy", 32'(cpu_busy),    32'd0);
        last_rdata = 8'h00;
        repeat (3) @(posedge hsclk);
        #1 resetb = 1'b1;
        repeat (40) @(posedge hsclk);
        #1;
        do_access(1'b1, 16'hFE40, 8'h00, 1'b0, lat);
        repeat (4) @(posedge hsclk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit: bench still running, required completion");
        $fatal(1, "time limit");
    end

endmodule
